// File: rtl/skein_out_pkg.sv
// Shared definitions for the Skein result output path:
// default sizes, sequencer state codes and a word-slice helper.
package skein_out_pkg;

    localparam int SK_NUM_WORDS = 16;
    localparam int SK_WORD_W    = 64;
    localparam int SK_IDX_W     = 4;

    typedef logic [1:0] seq_state_t;

    localparam seq_state_t ST_IDLE = 2'd0;
    localparam seq_state_t ST_LOAD = 2'd1;
    localparam seq_state_t ST_SEND = 2'd2;

    // Word k of a flattened result, word 0 in the least significant bits.
    function automatic logic [SK_WORD_W-1:0] word_slice(
        input logic [SK_NUM_WORDS*SK_WORD_W-1:0] flat,
        input int unsigned                      k
    );
        return flat[k*SK_WORD_W +: SK_WORD_W];
    endfunction

endpackage

// File: rtl/word_sequencer.sv
// Captures one completed Skein result and streams it out one word per
// valid/ready handshake, with the word index for the downstream word select.
module word_sequencer
    import skein_out_pkg::*;
#(
    parameter int NUM_WORDS = SK_NUM_WORDS,
    parameter int WORD_W    = SK_WORD_W,
    parameter int IDX_W     = SK_IDX_W
) (
    input  logic                        clk_i,
    input  logic                        rst_n_i,
    input  logic                        flush_i,
    input  logic                        result_valid_i,
    output logic                        result_ready_o,
    input  logic [NUM_WORDS*WORD_W-1:0] result_i,
    output logic                        word_valid_o,
    input  logic                        word_ready_i,
    output logic [WORD_W-1:0]           word_data_o,
    output logic [IDX_W-1:0]            word_idx_o,
    output logic                        word_last_o,
    output logic                        busy_o
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WORDS - 1);

    seq_state_t        state;
    logic [IDX_W-1:0]  idx;
    logic [WORD_W-1:0] buffer [NUM_WORDS];
    logic              capture;

    // A flush in IDLE discards the offered result even though ready is high.
    assign capture = (state == ST_IDLE) && result_valid_i && !flush_i;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state <= ST_IDLE;
            idx   <= '0;
        end else if (flush_i) begin
            state <= ST_IDLE;
            idx   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (result_valid_i) begin
                        state <= ST_LOAD;
                        idx   <= '0;
                    end
                end
                ST_LOAD: state <= ST_SEND;
                ST_SEND: begin
                    if (word_ready_i) begin
                        if (idx == LAST_IDX) begin
                            state <= ST_IDLE;
                            idx   <= '0;
                        end else begin
                            idx <= idx + IDX_W'(1);
                        end
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    idx   <= '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int k = 0; k < NUM_WORDS; k++) begin
                buffer[k] <= '0;
            end
        end else if (capture) begin
            for (int k = 0; k < NUM_WORDS; k++) begin
                buffer[k] <= result_i[k*WORD_W +: WORD_W];
            end
        end
    end

    // Outputs decode from registered state only, so they stay put while stalled.
    assign result_ready_o = (state == ST_IDLE);
    assign word_valid_o   = (state == ST_SEND);
    assign word_data_o    = buffer[idx];
    assign word_idx_o     = idx;
    assign word_last_o    = (state == ST_SEND) && (idx == LAST_IDX);
    assign busy_o         = (state == ST_LOAD) || (state == ST_SEND);

endmodule

// File: tb/tb_word_sequencer.sv
// Self-checking bench for word_sequencer: directed scenarios plus a
// randomized valid/ready run against a queue-based scoreboard.
module tb_word_sequencer;
    import skein_out_pkg::*;

    localparam int FLAT_W = SK_NUM_WORDS * SK_WORD_W;

    typedef struct packed {
        logic [SK_WORD_W-1:0] d;
        logic [SK_IDX_W-1:0]  i;
    } exp_word_t;

    logic                 clk;
    logic                 rst_n;
    logic                 flush;
    logic                 result_valid;
    logic                 result_ready;
    logic [FLAT_W-1:0]    result;
    logic                 word_valid;
    logic                 word_ready;
    logic [SK_WORD_W-1:0] word_data;
    logic [SK_IDX_W-1:0]  word_idx;
    logic                 word_last;
    logic                 busy;

    int compared   = 0;
    int mismatched = 0;

    word_sequencer dut (
        .clk_i          (clk),
        .rst_n_i        (rst_n),
        .flush_i        (flush),
        .result_valid_i (result_valid),
        .result_ready_o (result_ready),
        .result_i       (result),
        .word_valid_o   (word_valid),
        .word_ready_i   (word_ready),
        .word_data_o    (word_data),
        .word_idx_o     (word_idx),
        .word_last_o    (word_last),
        .busy_o         (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [FLAT_W-1:0] ramp_result();
        logic [FLAT_W-1:0] r;
        r = '0;
        for (int k = 0; k < SK_NUM_WORDS; k++) r[k*SK_WORD_W +: SK_WORD_W] = SK_WORD_W'(k);
        return r;
    endfunction

    function automatic logic [FLAT_W-1:0] rand_result();
        logic [FLAT_W-1:0] r;
        r = '0;
        for (int k = 0; k < SK_NUM_WORDS; k++) r[k*SK_WORD_W +: SK_WORD_W] = {$urandom, $urandom};
        return r;
    endfunction

    task automatic test_reset();
        rst_n = 1'b0; flush = 1'b0; result_valid = 1'b0; word_ready = 1'b0; result = '0;
        tick(); tick();
        compared++; if (result_ready !== 1'b1) begin mismatched++; $display("[TB] FAIL rst_ready: got %b expected 1", result_ready); end
        compared++; if (word_valid !== 1'b0) begin mismatched++; $display("[TB] FAIL rst_valid: got %b expected 0", word_valid); end
        compared++; if (word_data !== '0) begin mismatched++; $display("[TB] FAIL rst_data: got %h expected 0", word_data); end
        compared++; if (word_idx !== '0) begin mismatched++; $display("[TB] FAIL rst_idx: got %0d expected 0", word_idx); end
        compared++; if (word_last !== 1'b0) begin mismatched++; $display("[TB] FAIL rst_last: got %b expected 0", word_last); end
        compared++; if (busy !== 1'b0) begin mismatched++; $display("[TB] FAIL rst_busy: got %b expected 0", busy); end
        rst_n = 1'b1;
        tick();
        result = ramp_result(); result_valid = 1'b1; word_ready = 1'b1;
        tick();
        result_valid = 1'b0;
        tick();
        repeat (7) tick();
        compared++; if (word_idx !== 4'd7) begin mismatched++; $display("[TB] FAIL rst_pre_idx: got %0d expected 7", word_idx); end
        #3 rst_n = 1'b0;
        #1;
        compared++; if (result_ready !== 1'b1) begin mismatched++; $display("[TB] FAIL rst_mid_ready: got %b expected 1", result_ready); end
        compared++; if (word_valid !== 1'b0) begin mismatched++; $display("[TB] FAIL rst_mid_valid: got %b expected 0", word_valid); end
        compared++; if (word_idx !== '0) begin mismatched++; $display("[TB] FAIL rst_mid_idx: got %0d expected 0", word_idx); end
        compared++; if (busy !== 1'b0) begin mismatched++; $display("[TB] FAIL rst_mid_busy: got %b expected 0", busy); end
        tick();
        rst_n = 1'b1; word_ready = 1'b0;
        tick();
        compared++; if (busy !== 1'b0 || result_ready !== 1'b1) begin mismatched++; $display("[TB] FAIL rst_release: got busy=%b ready=%b expected busy=0 ready=1", busy, result_ready); end
    endtask

    task automatic test_full_burst();
        result = ramp_result(); result_valid = 1'b1; word_ready = 1'b1;
        tick();
        result_valid = 1'b0; result = '0;
        compared++; if (word_valid !== 1'b0 || busy !== 1'b1 || result_ready !== 1'b0) begin mismatched++; $display("[TB] FAIL burst_load: got valid=%b busy=%b ready=%b expected 0 1 0", word_valid, busy, result_ready); end
        for (int i = 0; i < SK_NUM_WORDS; i++) begin
            tick();
            compared++; if (word_valid !== 1'b1) begin mismatched++; $display("[TB] FAIL burst_valid[%0d]: got %b expected 1", i, word_valid); end
            compared++; if (word_idx !== SK_IDX_W'(i)) begin mismatched++; $display("[TB] FAIL burst_idx[%0d]: got %0d expected %0d", i, word_idx, i); end
            compared++; if (word_data !== SK_WORD_W'(i)) begin mismatched++; $display("[TB] FAIL burst_data[%0d]: got %h expected %h", i, word_data, i); end
            compared++; if (word_last !== (i == SK_NUM_WORDS - 1)) begin mismatched++; $display("[TB] FAIL burst_last[%0d]: got %b", i, word_last); end
        end
        tick();
        compared++; if (word_valid !== 1'b0 || busy !== 1'b0 || result_ready !== 1'b1) begin mismatched++; $display("[TB] FAIL burst_end: got valid=%b busy=%b ready=%b expected 0 0 1", word_valid, busy, result_ready); end
        word_ready = 1'b0;
    endtask

    task automatic test_back_pressure();
        result = ramp_result(); result_valid = 1'b1; word_ready = 1'b1;
        tick();
        result_valid = 1'b0;
        repeat (4) tick();
        compared++; if (word_idx !== 4'd3) begin mismatched++; $display("[TB] FAIL bp_pre_idx: got %0d expected 3", word_idx); end
        word_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            tick();
            compared++; if (word_valid !== 1'b1 || word_idx !== 4'd3 || word_data !== 64'd3 || word_last !== 1'b0) begin mismatched++; $display("[TB] FAIL bp_hold[%0d]: got valid=%b idx=%0d data=%h expected 1 3 3", c, word_valid, word_idx, word_data); end
        end
        word_ready = 1'b1;
        for (int i = 4; i < SK_NUM_WORDS; i++) begin
            tick();
            compared++; if (word_idx !== SK_IDX_W'(i) || word_data !== SK_WORD_W'(i)) begin mismatched++; $display("[TB] FAIL bp_drain[%0d]: got idx=%0d data=%h", i, word_idx, word_data); end
        end
        tick();
        compared++; if (result_ready !== 1'b1 || word_valid !== 1'b0) begin mismatched++; $display("[TB] FAIL bp_end: got ready=%b valid=%b expected 1 0", result_ready, word_valid); end
        word_ready = 1'b0;
    endtask

    task automatic test_mid_burst_offer();
        logic [FLAT_W-1:0] ra;
        logic [FLAT_W-1:0] rb;
        ra = rand_result(); rb = rand_result();
        result = ra; result_valid = 1'b1; word_ready = 1'b1;
        tick();
        result = rb;
        for (int i = 0; i < SK_NUM_WORDS; i++) begin
            tick();
            compared++; if (result_ready !== 1'b0) begin mismatched++; $display("[TB] FAIL mid_ready[%0d]: got %b expected 0", i, result_ready); end
            compared++; if (word_data !== word_slice(ra, i)) begin mismatched++; $display("[TB] FAIL mid_a_data[%0d]: got %h expected %h", i, word_data, word_slice(ra, i)); end
        end
        tick();
        compared++; if (result_ready !== 1'b1) begin mismatched++; $display("[TB] FAIL mid_idle_ready: got %b expected 1", result_ready); end
        tick();
        result_valid = 1'b0; result = '0;
        compared++; if (busy !== 1'b1 || word_valid !== 1'b0) begin mismatched++; $display("[TB] FAIL mid_b_load: got busy=%b valid=%b expected 1 0", busy, word_valid); end
        for (int i = 0; i < SK_NUM_WORDS; i++) begin
            tick();
            compared++; if (word_data !== word_slice(rb, i) || word_idx !== SK_IDX_W'(i)) begin mismatched++; $display("[TB] FAIL mid_b_data[%0d]: got %h idx=%0d expected %h", i, word_data, word_idx, word_slice(rb, i)); end
        end
        tick();
        word_ready = 1'b0;
        compared++; if (busy !== 1'b0) begin mismatched++; $display("[TB] FAIL mid_end: got busy=%b expected 0", busy); end
    endtask

    task automatic test_flush();
        result = rand_result(); result_valid = 1'b1; word_ready = 1'b1;
        tick();
        result_valid = 1'b0;
        repeat (10) tick();
        compared++; if (word_idx !== 4'd9) begin mismatched++; $display("[TB] FAIL fl_pre_idx: got %0d expected 9", word_idx); end
        flush = 1'b1;
        tick();
        flush = 1'b0;
        compared++; if (word_valid !== 1'b0 || word_idx !== '0 || result_ready !== 1'b1 || busy !== 1'b0) begin mismatched++; $display("[TB] FAIL fl_mid: got valid=%b idx=%0d ready=%b busy=%b expected 0 0 1 0", word_valid, word_idx, result_ready, busy); end
        // Flush coinciding with a capture offer: nothing should be taken.
        result = rand_result(); result_valid = 1'b1; flush = 1'b1;
        tick();
        flush = 1'b0; result_valid = 1'b0;
        compared++; if (result_ready !== 1'b1 || busy !== 1'b0 || word_valid !== 1'b0) begin mismatched++; $display("[TB] FAIL fl_idle: got ready=%b busy=%b valid=%b expected 1 0 0", result_ready, busy, word_valid); end
        tick();
        compared++; if (busy !== 1'b0 || word_valid !== 1'b0) begin mismatched++; $display("[TB] FAIL fl_idle_after: got busy=%b valid=%b expected 0 0", busy, word_valid); end
        // Flush coinciding with the last-word handshake.
        result = rand_result(); result_valid = 1'b1; word_ready = 1'b1;
        tick();
        result_valid = 1'b0;
        repeat (SK_NUM_WORDS) tick();
        compared++; if (word_last !== 1'b1) begin mismatched++; $display("[TB] FAIL fl_last_pre: got %b expected 1", word_last); end
        flush = 1'b1;
        tick();
        flush = 1'b0; word_ready = 1'b0;
        compared++; if (result_ready !== 1'b1 || word_valid !== 1'b0 || word_idx !== '0) begin mismatched++; $display("[TB] FAIL fl_last: got ready=%b valid=%b idx=%0d expected 1 0 0", result_ready, word_valid, word_idx); end
    endtask

    task automatic test_random();
        exp_word_t         q[$];
        logic [FLAT_W-1:0] cur;
        int                accepted;
        int                cycles;
        bit                pending;
        bit                just_cap;
        bit                hs_w;
        bit                hs_r;
        accepted = 0; cycles = 0; pending = 1'b0; just_cap = 1'b0; cur = '0;
        while ((accepted < 1000 || q.size() != 0) && cycles < 80000) begin
            compared++; if (result_ready !== (q.size() == 0)) begin mismatched++; $display("[TB] FAIL rnd_ready @%0d: got %b pending_words=%0d", cycles, result_ready, q.size()); end
            compared++; if (word_valid !== (q.size() != 0 && !just_cap)) begin mismatched++; $display("[TB] FAIL rnd_valid @%0d: got %b pending_words=%0d", cycles, word_valid, q.size()); end
            if (!pending && accepted < 1000 && $urandom_range(0, 3) != 0) begin
                cur = rand_result();
                pending = 1'b1;
            end
            result_valid = pending;
            result = cur;
            word_ready = ($urandom_range(0, 3) != 0);
            hs_r = pending && (result_ready === 1'b1);
            hs_w = (word_valid === 1'b1) && word_ready;
            if (hs_w) begin
                compared++;
                if (q.size() == 0) begin
                    mismatched++; $display("[TB] FAIL rnd_extra @%0d: got word %h with nothing outstanding", cycles, word_data);
                end else if (word_data !== q[0].d || word_idx !== q[0].i || word_last !== (q[0].i == SK_IDX_W'(SK_NUM_WORDS - 1))) begin
                    mismatched++; $display("[TB] FAIL rnd_word @%0d: got data=%h idx=%0d last=%b expected data=%h idx=%0d", cycles, word_data, word_idx, word_last, q[0].d, q[0].i);
                end
            end
            tick();
            cycles++;
            just_cap = hs_r;
            if (hs_w && q.size() != 0) void'(q.pop_front());
            if (hs_r) begin
                for (int k = 0; k < SK_NUM_WORDS; k++) q.push_back('{d: word_slice(cur, k), i: SK_IDX_W'(k)});
                pending = 1'b0;
                accepted++;
            end
        end
        result_valid = 1'b0; word_ready = 1'b0;
        compared++; if (accepted != 1000 || q.size() != 0) begin mismatched++; $display("[TB] FAIL rnd_complete: got accepted=%0d outstanding=%0d expected 1000 0", accepted, q.size()); end
    endtask

    initial begin
        test_reset();
        test_full_burst();
        test_back_pressure();
        test_mid_burst_offer();
        test_flush();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
